// File: rtl/dwg_pkg.sv
// Shared constants, FSM state codes and channel-width helper for dwg_delay_line.
// The RD1 state code exists only when DWG_DL_INTERP_EN is defined.
package dwg_pkg;

    localparam int DEF_DATA_W = 18;
    localparam int DEF_ADDR_W = 11;
    localparam int DEF_FRAC_W = 8;

    localparam logic [2:0] ST_CLR  = 3'd0;
    localparam logic [2:0] ST_IDLE = 3'd1;
    localparam logic [2:0] ST_RD0  = 3'd2;
`ifdef DWG_DL_INTERP_EN
    localparam logic [2:0] ST_RD1  = 3'd3;
`endif
    localparam logic [2:0] ST_WR   = 3'd4;
    localparam logic [2:0] ST_OUT  = 3'd5;

    function automatic int ch_w(input int nch);
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

endpackage

// File: rtl/dwg_spram.sv
// Single-port synchronous RAM, read-before-write, one cycle read latency.
module dwg_spram #(
    parameter int DW    = 18,
    parameter int DEPTH = 2048,
    localparam int AW   = (DEPTH <= 1) ? 1 : $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] dout_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout_q <= mem[addr];
    end

    assign dout = dout_q;

endmodule

// File: rtl/dwg_delay_line.sv
// Multi-channel digital-waveguide delay line: one circular buffer per channel in a shared RAM.
// Define DWG_DL_INTERP_EN to add a second tap read and linear fractional-delay interpolation.
module dwg_delay_line
    import dwg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NCH    = 1,
    parameter int FRAC_W = DEF_FRAC_W,
    localparam int CH_W  = ch_w(NCH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] dly_int,
    input  logic [FRAC_W-1:0] dly_frac,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic [DATA_W-1:0] out_data
);

    localparam int DEPTH = NCH * (1 << ADDR_W);
    localparam int RAW   = $clog2(DEPTH);
    localparam int NPTR  = 1 << CH_W;
    localparam logic [RAW-1:0] LAST_ADDR = RAW'(DEPTH - 1);
    localparam logic [CH_W:0]  NCH_L     = (CH_W + 1)'(NCH);

    logic [2:0]        state_q, state_d;
    logic [RAW-1:0]    clr_addr_q, clr_addr_d;
    logic [ADDR_W-1:0] wptr_q [NPTR];
    logic [ADDR_W-1:0] wptr_d [NPTR];
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              ch_ok_q, ch_ok_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] dly_q, dly_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic              ram_we;
    logic [RAW-1:0]    ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    logic [ADDR_W-1:0] cur_wptr;
    logic [ADDR_W-1:0] rd_ptr0;
    logic [ADDR_W-1:0] dly_clamped;
    logic [DATA_W-1:0] tap_result;

`ifdef DWG_DL_INTERP_EN
    localparam logic [ADDR_W-1:0] D_MAX = ADDR_W'((1 << ADDR_W) - 2);

    logic [FRAC_W-1:0]             frac_q, frac_d;
    logic [DATA_W-1:0]             s0_q, s0_d;
    logic [ADDR_W-1:0]             rd_ptr1;
    logic signed [DATA_W:0]        diff;
    logic signed [DATA_W+FRAC_W+1:0] prod;
    logic signed [DATA_W+FRAC_W+1:0] prod_sh;

    assign rd_ptr1 = rd_ptr0 - ADDR_W'(1);
    assign diff    = $signed({ram_dout[DATA_W-1], ram_dout}) - $signed({s0_q[DATA_W-1], s0_q});
    assign prod    = diff * $signed({1'b0, frac_q});
    assign prod_sh = prod >>> FRAC_W;
    // Only the low DATA_W bits survive truncation, so the add can be done at output width.
    assign tap_result = s0_q + prod_sh[DATA_W-1:0];
`else
    logic unused_frac;
    assign unused_frac = ^dly_frac;
    assign tap_result  = ram_dout;
`endif

    assign cur_wptr = wptr_q[ch_q];
    assign rd_ptr0  = cur_wptr - dly_q;

    always_comb begin
        dly_clamped = (dly_int == '0) ? ADDR_W'(1) : dly_int;
`ifdef DWG_DL_INTERP_EN
        if (dly_clamped > D_MAX) begin
            dly_clamped = D_MAX;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        wptr_d     = wptr_q;
        ch_d       = ch_q;
        ch_ok_d    = ch_ok_q;
        data_d     = data_q;
        dly_d      = dly_q;
        out_ch_d   = out_ch_q;
        out_data_d = out_data_q;
`ifdef DWG_DL_INTERP_EN
        frac_d     = frac_q;
        s0_d       = s0_q;
`endif
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_din    = data_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;

        case (state_q)
            ST_CLR: begin
                ram_we     = 1'b1;
                ram_addr   = clr_addr_q;
                ram_din    = '0;
                clr_addr_d = clr_addr_q + RAW'(1);
                if (clr_addr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ch_d    = in_ch;
                    ch_ok_d = ({1'b0, in_ch} < NCH_L);
                    data_d  = in_data;
                    dly_d   = dly_clamped;
`ifdef DWG_DL_INTERP_EN
                    frac_d  = dly_frac;
`endif
                    state_d = ST_RD0;
                end
            end
            ST_RD0: begin
                // Out-of-range channels never touch the RAM; their result is forced to zero.
                ram_addr = ch_ok_q ? RAW'({ch_q, rd_ptr0}) : '0;
`ifdef DWG_DL_INTERP_EN
                state_d  = ST_RD1;
`else
                state_d  = ST_WR;
`endif
            end
`ifdef DWG_DL_INTERP_EN
            ST_RD1: begin
                ram_addr = ch_ok_q ? RAW'({ch_q, rd_ptr1}) : '0;
                s0_d     = ram_dout;
                state_d  = ST_WR;
            end
`endif
            ST_WR: begin
                if (ch_ok_q) begin
                    ram_we         = 1'b1;
                    ram_addr       = RAW'({ch_q, cur_wptr});
                    wptr_d[ch_q]   = cur_wptr + ADDR_W'(1);
                end
                out_ch_d   = ch_q;
                out_data_d = ch_ok_q ? tap_result : '0;
                state_d    = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d    = ST_CLR;
                clr_addr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_CLR;
            clr_addr_q <= '0;
            for (int i = 0; i < NPTR; i++) begin
                wptr_q[i] <= '0;
            end
            ch_q       <= '0;
            ch_ok_q    <= 1'b0;
            data_q     <= '0;
            dly_q      <= '0;
            out_ch_q   <= '0;
            out_data_q <= '0;
`ifdef DWG_DL_INTERP_EN
            frac_q     <= '0;
            s0_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            wptr_q     <= wptr_d;
            ch_q       <= ch_d;
            ch_ok_q    <= ch_ok_d;
            data_q     <= data_d;
            dly_q      <= dly_d;
            out_ch_q   <= out_ch_d;
            out_data_q <= out_data_d;
`ifdef DWG_DL_INTERP_EN
            frac_q     <= frac_d;
            s0_q       <= s0_d;
`endif
        end
    end

    assign out_ch   = out_ch_q;
    assign out_data = out_data_q;

    dwg_spram #(
        .DW    (DATA_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (ram_din),
        .dout (ram_dout)
    );

endmodule

// File: tb/tb_dwg_delay_line.sv
// Self-checking bench for dwg_delay_line: a default single-channel instance and a small two-channel one,
// checked against a sample-history reference model (honours DWG_DL_INTERP_EN).
module tb_dwg_delay_line;

`ifdef DWG_DL_INTERP_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif
    localparam int FW    = 8;
    localparam int HSIZE = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults (NCH=1, ADDR_W=11).
    logic        rst_a = 1'b1;
    logic        v_a = 1'b0;
    logic        rdy_a;
    logic [0:0]  ch_a = '0;
    logic [17:0] data_a = '0;
    logic [10:0] dly_a = '0;
    logic [7:0]  frac_a = '0;
    logic        ov_a;
    logic [0:0]  och_a;
    logic [17:0] od_a;

    // Instance B: two channels, 16-deep buffers.
    logic        rst_b = 1'b1;
    logic        v_b = 1'b0;
    logic        rdy_b;
    logic [0:0]  ch_b = '0;
    logic [17:0] data_b = '0;
    logic [3:0]  dly_b = '0;
    logic [7:0]  frac_b = '0;
    logic        ov_b;
    logic [0:0]  och_b;
    logic [17:0] od_b;

    dwg_delay_line dut_a (
        .clk(clk), .reset(rst_a), .in_valid(v_a), .in_ready(rdy_a), .in_ch(ch_a),
        .in_data(data_a), .dly_int(dly_a), .dly_frac(frac_a),
        .out_valid(ov_a), .out_ch(och_a), .out_data(od_a)
    );

    dwg_delay_line #(.ADDR_W(4), .NCH(2)) dut_b (
        .clk(clk), .reset(rst_b), .in_valid(v_b), .in_ready(rdy_b), .in_ch(ch_b),
        .in_data(data_b), .dly_int(dly_b), .dly_frac(frac_b),
        .out_valid(ov_b), .out_ch(och_b), .out_data(od_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: every accepted sample per (instance, channel) in write order.
    logic [17:0] hist [4][HSIZE];
    int          hcnt [4];

    function automatic logic rdy(input int sel);
        return (sel != 0) ? rdy_b : rdy_a;
    endfunction
    function automatic logic ov(input int sel);
        return (sel != 0) ? ov_b : ov_a;
    endfunction
    function automatic logic [17:0] od(input int sel);
        return (sel != 0) ? od_b : od_a;
    endfunction
    function automatic logic och(input int sel);
        return (sel != 0) ? och_b[0] : och_a[0];
    endfunction

    function automatic logic [17:0] sample_ago(input int k, input int d);
        if (hcnt[k] >= d) return hist[k][(hcnt[k] - d) % HSIZE];
        return '0;
    endfunction

    function automatic logic [17:0] model_tap(input int k, input int dly, input int frac, input int depth);
        int d;
        d = (dly == 0) ? 1 : dly;
`ifdef DWG_DL_INTERP_EN
        begin
            longint a, b, r;
            logic [63:0] rv;
            if (d > depth - 2) d = depth - 2;
            a  = longint'($signed(sample_ago(k, d)));
            b  = longint'($signed(sample_ago(k, d + 1)));
            r  = a + (((b - a) * longint'(frac)) >>> FW);
            rv = r;
            return rv[17:0];
        end
`else
        if (depth < 0 || frac < 0) return '0;
        return sample_ago(k, d);
`endif
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model(input int sel);
        hcnt[sel * 2]     = 0;
        hcnt[sel * 2 + 1] = 0;
    endtask

    task automatic wait_ready(input int sel);
        int n;
        n = 0;
        @(negedge clk);
        while (rdy(sel) !== 1'b1 && n < 10000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10000) check_output("ready_timeout", 32'(rdy(sel)), 32'd1);
    endtask

    // Reset, check reset values, then measure how long the clear sweep holds in_ready low.
    task automatic do_reset(input int sel, input int depth);
        int n;
        bit seen_ov;
        @(negedge clk);
        if (sel != 0) rst_b = 1'b1; else rst_a = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_output("rst_out_valid", 32'(ov(sel)), 32'd0);
        check_output("rst_out_data", 32'(od(sel)), 32'd0);
        check_output("rst_out_ch", 32'(och(sel)), 32'd0);
        check_output("rst_in_ready", 32'(rdy(sel)), 32'd0);
        if (sel != 0) rst_b = 1'b0; else rst_a = 1'b0;
        n = 0;
        seen_ov = 1'b0;
        while (rdy(sel) !== 1'b1 && n <= depth + 10) begin
            @(posedge clk);
            #1;
            n++;
            if (ov(sel) !== 1'b0) seen_ov = 1'b1;
        end
        check_output("clr_cycles", 32'(n), 32'(depth));
        check_output("clr_no_out_valid", 32'(seen_ov), 32'd0);
        clear_model(sel);
    endtask

    task automatic apply_stimulus(input int sel, input int ch, input logic [17:0] data,
                                  input int dly, input int frac);
        int k, nch, depth;
        logic [17:0] exp;
        nch   = (sel != 0) ? 2 : 1;
        depth = (sel != 0) ? 16 : 2048;
        k     = sel * 2 + ch;
        exp   = (ch < nch) ? model_tap(k, dly, frac, depth) : '0;
        wait_ready(sel);
        if (sel != 0) begin
            v_b = 1'b1; ch_b = 1'(ch); data_b = data; dly_b = 4'(dly); frac_b = 8'(frac);
        end else begin
            v_a = 1'b1; ch_a = 1'(ch); data_a = data; dly_a = 11'(dly); frac_a = 8'(frac);
        end
        @(posedge clk);
        #1;
        v_a = 1'b0;
        v_b = 1'b0;
        check_output("ov_early", 32'(ov(sel)), 32'd0);
        for (int c = 2; c <= LAT; c++) begin
            @(posedge clk);
            #1;
            check_output("ov_timing", 32'(ov(sel)), 32'(c == LAT));
        end
        check_output("out_data", 32'(od(sel)), 32'(exp));
        check_output("out_ch", 32'(och(sel)), 32'(ch));
        @(posedge clk);
        #1;
        check_output("ov_one_cycle", 32'(ov(sel)), 32'd0);
        check_output("ready_again", 32'(rdy(sel)), 32'd1);
        check_output("out_data_hold", 32'(od(sel)), 32'(exp));
        if (ch < nch) begin
            hist[k][hcnt[k] % HSIZE] = data;
            hcnt[k]++;
        end
    endtask

    initial begin
        logic [17:0] rnd;
        bit seen_ov;
        int n;
        for (int i = 0; i < 4; i++) hcnt[i] = 0;

        $display("[TB] reset and clear sweep, instance A");
        do_reset(0, 2048);
        apply_stimulus(0, 0, 18'h12345, 5, 0);

        $display("[TB] ramp with delay 4");
        do_reset(0, 2048);
        for (int i = 1; i <= 12; i++) apply_stimulus(0, 0, 18'(i), 4, 0);

        $display("[TB] zero delay behaves as one");
        for (int i = 0; i < 4; i++) begin
            rnd = 18'($urandom);
            apply_stimulus(0, 0, rnd, 0, int'($urandom_range(0, 255)));
        end

        $display("[TB] random traffic across pointer wrap");
        for (int i = 0; i < 2100; i++) begin
            rnd = 18'($urandom);
            apply_stimulus(0, 0, rnd, (i % 7 == 0) ? 0 : int'($urandom_range(1, 2047)),
                           int'($urandom_range(0, 255)));
        end
        for (int i = 0; i < 5; i++) apply_stimulus(0, 0, 18'($urandom), 2047, 0);

        $display("[TB] out-of-range channel");
        apply_stimulus(0, 1, 18'h2AAAA, 1, 0);
        apply_stimulus(0, 0, 18'h00777, 1, 0);

        $display("[TB] reset during RD0");
        wait_ready(0);
        v_a = 1'b1; ch_a = '0; data_a = 18'h1F00F; dly_a = 11'd1; frac_a = '0;
        @(posedge clk);
        #1;
        v_a = 1'b0;
        rst_a = 1'b1;
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        check_output("abort_in_ready", 32'(rdy_a), 32'd0);
        n = 0;
        seen_ov = 1'b0;
        while (rdy_a !== 1'b1 && n <= 2100) begin
            @(posedge clk);
            #1;
            n++;
            if (ov_a !== 1'b0) seen_ov = 1'b1;
        end
        check_output("abort_no_ov", 32'(seen_ov), 32'd0);
        check_output("abort_clr_cycles", 32'(n), 32'd2048);
        clear_model(0);
        apply_stimulus(0, 0, 18'h00001, 1, 0);
        apply_stimulus(0, 0, 18'h00002, 3, 0);

`ifdef DWG_DL_INTERP_EN
        $display("[TB] interpolation midpoint");
        do_reset(0, 2048);
        apply_stimulus(0, 0, 18'd200, 1, 0);
        apply_stimulus(0, 0, 18'd100, 1, 0);
        apply_stimulus(0, 0, 18'd0, 1, 128);
        check_output("interp_150", 32'(od_a), 32'd150);
        for (int i = 0; i < 20; i++)
            apply_stimulus(0, 0, 18'($urandom), int'($urandom_range(0, 2047)), int'($urandom_range(0, 255)));
`endif

        $display("[TB] two channels, instance B");
        do_reset(1, 32);
        for (int i = 1; i <= 10; i++) begin
            apply_stimulus(1, 0, 18'(i), 3, 0);
            apply_stimulus(1, 1, 18'h3FF9C, 3, 0);
        end
        for (int i = 0; i < 60; i++) begin
            apply_stimulus(1, int'($urandom_range(0, 1)), 18'($urandom),
                           int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dwg_delay_line.md
DWG_DELAY_LINE -- requirements
Module: dwg_delay_line

Interface
REQ-001 SHALL have parameter DATA_W, default 18, sample width (two's complement).
REQ-002 SHALL have parameter ADDR_W, default 11, per-channel buffer depth 2^ADDR_W.
REQ-003 SHALL have parameter NCH, default 1, channel count; CH_W = max(1, clog2(NCH)).
REQ-004 SHALL have parameter FRAC_W, default 8, fractional delay width (used only under DWG_DL_INTERP_EN).
REQ-005 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-006 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports: in_valid  in  1  sample offered.
REQ-008 SHALL have ports: in_ready  out  1  sample accepted when in_valid & in_ready.
REQ-009 SHALL have ports: in_ch  in  CH_W  channel of offered sample.
REQ-010 SHALL have ports: in_data  in  DATA_W  sample to write.
REQ-011 SHALL have ports: dly_int  in  ADDR_W  integer delay in samples.
REQ-012 SHALL have ports: dly_frac  in  FRAC_W  fractional delay (ignored without DWG_DL_INTERP_EN).
REQ-013 SHALL have ports: out_valid  out  1  one-cycle pulse, tap result valid.
REQ-014 SHALL have ports: out_ch  out  CH_W  channel of result.
REQ-015 SHALL have ports: out_data  out  DATA_W  delayed tap.

Function
REQ-016 SHALL keep one circular buffer per channel in a single-port RAM of NCH*2^ADDR_W words, address {ch, ptr}, synchronous read, 1-cycle read latency.
REQ-017 SHALL keep per-channel write pointer wptr[ch], ADDR_W bits, modulo-2^ADDR_W wrap.
REQ-018 SHALL use FSM states CLR, IDLE, RD0, RD1, WR, OUT; in_ready high only in IDLE.
REQ-019 SHALL latch in_ch, in_data, dly_int, dly_frac on acceptance (IDLE->RD0).
REQ-020 SHALL in RD0 read address wptr - D (mod 2^ADDR_W), D = clamped dly_int.
REQ-021 SHALL clamp D: 0 -> 1; no upper clamp without interpolation (max 2^ADDR_W-1).
REQ-022 SHALL in WR write latched in_data at wptr[ch], then increment wptr[ch]; other channels' pointers unchanged.
REQ-023 SHALL in OUT assert out_valid for exactly one cycle with registered out_ch/out_data, then return to IDLE.
REQ-024 SHALL, without interpolation, go RD0->WR->OUT: accept at cycle N, out_valid at N+3, in_ready again at N+4.
REQ-025 SHALL hold out_data/out_ch stable between out_valid pulses.
REQ-026 SHALL ignore in_ch >= NCH: sample accepted, no RAM write, no pointer change, out_valid pulses with out_data = 0.

Reset
REQ-027 SHALL on reset: all wptr = 0, out_valid = 0, out_data = 0, out_ch = 0, in_ready = 0, state CLR with sweep address 0.
REQ-028 SHALL in CLR write 0 to every RAM address, one per cycle, then enter IDLE; in_ready rises NCH*2^ADDR_W cycles after reset deasserts.
REQ-029 SHALL on reset asserted in any state (mid-sweep, mid-transaction) abort, drop any in-flight sample and restart CLR; no out_valid for it.

Configuration
REQ-030 SHALL, with DWG_DL_INTERP_EN defined, insert RD1 (read wptr - D - 1) between RD0 and WR; out_data = s0 + ((s1 - s0) * dly_frac) >>> FRAC_W, full-precision intermediate, truncated to DATA_W; latency N+4.
REQ-031 SHALL, with DWG_DL_INTERP_EN defined, clamp D to 2^ADDR_W-2 maximum.
REQ-032 SHALL, without DWG_DL_INTERP_EN, contain no RD1 state, no multiplier, and ignore dly_frac.

Structure
REQ-033 SHALL place FSM state enumeration, default DATA_W/ADDR_W/FRAC_W constants and CH_W function in shared package dwg_pkg.
REQ-034 SHALL instantiate one sub-module dwg_spram (parametrised single-port synchronous RAM: clk, we, addr, din, dout).

Verification
REQ-035 SHALL cover: after reset, in_ready low 2048 cycles (defaults), then first tap with dly_int=5 returns 0.
REQ-036 SHALL cover: write ramp 1,2,3,... on ch0 with dly_int=4 -> k-th output = k-4 (0 for k<=4); out_valid exactly 3 cycles after each accept.
REQ-037 SHALL cover: dly_int=0 -> behaves as 1; dly_int=2047 after 2100 samples -> output = sample written 2047 earlier across pointer wrap.
REQ-038 SHALL cover: NCH=2, interleaved ch0 ramp and ch1 constant -100, dly_int=3 -> channels independent, out_ch matches.
REQ-039 SHALL cover: reset asserted in RD0 -> no out_valid, CLR restarts, previously written data reads back 0.
REQ-040 SHALL cover, with DWG_DL_INTERP_EN: s0=100, s1=200, dly_frac=128 (FRAC_W=8) -> out_data=150, out_valid at N+4.
